led_flash_ctrl: RTL

//  Multi-channel LED flasher. A shared prescaler generates a tick strobe. Each

---
 rtl/led_pkg.sv | 17 +
 rtl/led_flash_ctrl_if.sv | 23 ++
 rtl/led_channel.sv | 93 +++++++++
 rtl/led_flash_ctrl.sv | 67 ++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding for the LED flasher.
// Used by the top, the channel block and the bench.
package led_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic [1:0] {
      M_OFF   = MODE_OFF,
      M_ON    = MODE_ON,
      M_BLINK = MODE_BLINK,
      M_BURST = MODE_BURST
   } led_mode_t;

endpackage

// File: rtl/led_flash_ctrl_if.sv
// Single-cycle configuration port of the LED flasher.
// master drives a write, slave (the flasher) samples it.
interface led_flash_ctrl_if #(
   parameter int CH_W  = 2,
   parameter int PER_W = 16,
   parameter int CNT_W = 8
) ();

   logic             cfg_wr;
   logic [CH_W-1:0]  cfg_ch;
   logic [1:0]       cfg_mode;
   logic [PER_W-1:0] cfg_half;
   logic [CNT_W-1:0] cfg_cnt;

   modport master (
      output cfg_wr, cfg_ch, cfg_mode, cfg_half, cfg_cnt
   );

   modport slave (
      input cfg_wr, cfg_ch, cfg_mode, cfg_half, cfg_cnt
   );

endinterface

// File: rtl/led_channel.sv
// One LED channel: mode register, phase and burst counters.
// A write always wins over a tick arriving in the same cycle.
module led_channel
   import led_pkg::*;
#(
   parameter int PER_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             wr,
   input  led_mode_t        wr_mode,
   input  logic [PER_W-1:0] wr_half,
   input  logic [CNT_W-1:0] wr_cnt,
   input  logic             tick,
   output logic             led,
   output logic             burst_done
);

   localparam logic [PER_W-1:0] H_ONE = PER_W'(1);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   led_mode_t        mode_q, mode_d;
   logic [PER_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [PER_W-1:0] ph_q, ph_d;
   logic             led_d;
   logic             done_d;

   // State register for mode, counters and the registered outputs
   always_ff @(posedge sclk) begin
      if (rst) begin
         mode_q     <= M_OFF;
         half_q     <= H_ONE;
         rem_q      <= '0;
         ph_q       <= '0;
         led        <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         half_q     <= half_d;
         rem_q      <= rem_d;
         ph_q       <= ph_d;
         led        <= led_d;
         burst_done <= done_d;
      end
   end

   // Next state: write restarts the channel, else ticks advance the phase
   always_comb begin
      mode_d = mode_q;
      half_d = half_q;
      rem_d  = rem_q;
      ph_d   = ph_q;
      led_d  = led;
      done_d = 1'b0;
      if (wr) begin
         mode_d = wr_mode;
         half_d = (wr_half == '0) ? H_ONE : wr_half;
         rem_d  = wr_cnt;
         ph_d   = '0;
         unique case (wr_mode)
            M_OFF:   led_d = 1'b0;
            M_ON:    led_d = 1'b1;
            M_BLINK: led_d = 1'b1;
            M_BURST: begin
               if (wr_cnt != '0) begin
                  led_d = 1'b1;
               end else begin
                  led_d  = 1'b0;
                  mode_d = M_OFF;
                  done_d = 1'b1;
               end
            end
         endcase
      end else if (tick && (mode_q == M_BLINK || mode_q == M_BURST)) begin
         if (ph_q == half_q - H_ONE) begin
            ph_d  = '0;
            led_d = ~led;
            if (mode_q == M_BURST && led) begin
               rem_d = rem_q - C_ONE;
               if (rem_q == C_ONE) begin
                  mode_d = M_OFF;
                  done_d = 1'b1;
               end
            end
         end else begin
            ph_d = ph_q + H_ONE;
         end
      end
   end

endmodule

// File: rtl/led_flash_ctrl.sv
// Multi-channel LED flasher: shared tick prescaler,
// write decode and one led_channel per LED.
module led_flash_ctrl
   import led_pkg::*;
#(
   parameter int  CLK_FREQ_HZ = 50_000_000,
   parameter int  TICK_HZ     = 1_000,
   parameter int  NUM_CH      = 4,
   parameter int  PER_W       = 16,
   parameter int  CNT_W       = 8,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              sclk,
   input  logic              rst,
   led_flash_ctrl_if.slave   cfg,
   output logic              tick,
   output logic [NUM_CH-1:0] led,
   output logic [NUM_CH-1:0] burst_done
);

   localparam int DIV    = CLK_FREQ_HZ / TICK_HZ;
   localparam int PRES_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PRES_W-1:0] PRES_MAX = PRES_W'(DIV - 1);

   logic [PRES_W-1:0] pres_cnt;
   logic [NUM_CH-1:0] wr_sel;
   led_mode_t         wr_mode;

   // Prescaler; tick is registered so it lands one cycle after the wrap value
   always_ff @(posedge sclk) begin
      if (rst) begin
         pres_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         pres_cnt <= (pres_cnt == PRES_MAX) ? '0 : pres_cnt + PRES_W'(1);
         tick     <= (pres_cnt == PRES_MAX);
      end
   end

   // Channel select; writes to a channel index past NUM_CH hit nothing
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i] = cfg.cfg_wr && (int'(cfg.cfg_ch) == i);
      end
   end

   assign wr_mode = led_mode_t'(cfg.cfg_mode);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      led_channel #(
         .PER_W (PER_W),
         .CNT_W (CNT_W)
      ) u_ch (
         .sclk       (sclk),
         .rst        (rst),
         .wr         (wr_sel[g]),
         .wr_mode    (wr_mode),
         .wr_half    (cfg.cfg_half),
         .wr_cnt     (cfg.cfg_cnt),
         .tick       (tick),
         .led        (led[g]),
         .burst_done (burst_done[g])
      );
   end

endmodule
